// File: rtl/ibpl_pkg.sv
// ibpl_pkg: shared types and default parameters for the input conditioner
package ibpl_pkg;
    typedef enum logic {ST_STABLE, ST_PENDING} ibpl_deb_state_t;
    localparam int FILT_W_DEF      = 8;
    localparam int STRETCH_LEN_DEF = 6250000;
    localparam int STRETCH_W_DEF   = 23;
endpackage

// File: rtl/ibpl_in_chan.sv
// ibpl_in_chan: one input channel - 2-flop synchroniser, debounce, edge strobes, activity stretch
//  clk_sys, rstn_sys : clock, async active-low reset
//  raw               : asynchronous input level
//  enable            : 0 holds the channel idle (sync clear)
//  filt_len          : debounce length in cycles
//  clean/rise/fall   : debounced level and 1-cycle edge strobes
//  act               : high while the stretch counter is non-zero
module ibpl_in_chan
    import ibpl_pkg::*;
#(
    parameter int FILT_W      = FILT_W_DEF,
    parameter int STRETCH_LEN = STRETCH_LEN_DEF,
    parameter int STRETCH_W   = STRETCH_W_DEF
)(
    input  logic              clk_sys,
    input  logic              rstn_sys,
    input  logic              raw,
    input  logic              enable,
    input  logic [FILT_W-1:0] filt_len,
    output logic              clean,
    output logic              rise,
    output logic              fall,
    output logic              act
);
    logic                 s1, s2;
    ibpl_deb_state_t      state;
    logic [FILT_W-1:0]    cnt;
    logic [STRETCH_W-1:0] stretch, stretch_nxt;
    logic                 diff, commit;

    always_comb begin
        diff        = s2 != clean;
        commit      = diff && (state == ST_STABLE ? filt_len == '0 : cnt >= filt_len);
        // the stretch reloads from the registered strobe, so activity starts the edge after it
        stretch_nxt = (rise || fall) ? STRETCH_W'(STRETCH_LEN) :
                      (stretch != '0) ? stretch - STRETCH_W'(1) : '0;
    end

    // synchroniser keeps running regardless of enable
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state   <= ST_STABLE;
            cnt     <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            stretch <= '0;
            act     <= 1'b0;
        end else if (!enable) begin
            state   <= ST_STABLE;
            cnt     <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            stretch <= '0;
            act     <= 1'b0;
        end else begin
            rise    <= commit && s2;
            fall    <= commit && !s2;
            stretch <= stretch_nxt;
            act     <= stretch_nxt != '0;
            if (!diff || commit) begin
                state <= ST_STABLE;
                cnt   <= '0;
                if (commit) clean <= s2;
            end else begin
                state <= ST_PENDING;
                cnt   <= state == ST_STABLE ? FILT_W'(1) : cnt + FILT_W'(1);
            end
        end
    end
endmodule

// File: rtl/ibpl_input_conditioner.sv
// ibpl_input_conditioner: per-channel sync/debounce/strobe/activity conditioning of internal_in
//  clk_sys, rstn_sys : clock, async active-low reset
//  internal_in       : raw asynchronous input levels
//  input_enable      : per-channel enable, 0 forces the channel idle
//  filt_len          : debounce length shared by all channels
//  in_clean          : debounced levels
//  in_rise, in_fall  : 1-cycle edge strobes of in_clean
//  input_act         : pulse-stretched activity flags for the LED bus
module ibpl_input_conditioner
    import ibpl_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int FILT_W      = FILT_W_DEF,
    parameter int STRETCH_LEN = STRETCH_LEN_DEF,
    parameter int STRETCH_W   = STRETCH_W_DEF
)(
    input  logic                clk_sys,
    input  logic                rstn_sys,
    input  logic [CHANNELS-1:0] internal_in,
    input  logic [CHANNELS-1:0] input_enable,
    input  logic [FILT_W-1:0]   filt_len,
    output logic [CHANNELS-1:0] in_clean,
    output logic [CHANNELS-1:0] in_rise,
    output logic [CHANNELS-1:0] in_fall,
    output logic [CHANNELS-1:0] input_act
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ibpl_in_chan #(
            .FILT_W     (FILT_W),
            .STRETCH_LEN(STRETCH_LEN),
            .STRETCH_W  (STRETCH_W)
        ) u_chan (
            .clk_sys (clk_sys),
            .rstn_sys(rstn_sys),
            .raw     (internal_in[i]),
            .enable  (input_enable[i]),
            .filt_len(filt_len),
            .clean   (in_clean[i]),
            .rise    (in_rise[i]),
            .fall    (in_fall[i]),
            .act     (input_act[i])
        );
    end
endmodule

// File: tb/tb_ibpl_input_conditioner.sv
// tb_ibpl_input_conditioner: directed scenarios plus randomized run against a run-length reference model
module tb_ibpl_input_conditioner;
    localparam int N   = 8;
    localparam int LEN = 10;

    logic         clk_sys = 1'b0;
    logic         rstn_sys = 1'b1;
    logic [N-1:0] internal_in = '0;
    logic [N-1:0] input_enable = '0;
    logic [7:0]   filt_len = '0;
    logic [N-1:0] in_clean, in_rise, in_fall, input_act;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    // reference model: sync pipeline, count of consecutive differing samples,
    // and the edge at which the last activity load happened
    logic [N-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_act;
    int           m_run[N];
    int           m_load[N];
    bit           m_has[N];

    ibpl_input_conditioner #(
        .CHANNELS(N), .FILT_W(8), .STRETCH_LEN(LEN), .STRETCH_W(4)
    ) dut (
        .clk_sys(clk_sys), .rstn_sys(rstn_sys), .internal_in(internal_in),
        .input_enable(input_enable), .filt_len(filt_len), .in_clean(in_clean),
        .in_rise(in_rise), .in_fall(in_fall), .input_act(input_act)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset;
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_act = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_load[c] = 0; m_has[c] = 0;
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        edge_n++;
        if (!rstn_sys) model_reset();
        else begin
            for (int c = 0; c < N; c++) begin
                logic ns1, ns2;
                ns1 = internal_in[c];
                ns2 = m_s1[c];
                if (!input_enable[c]) begin
                    m_clean[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_has[c] = 0;
                end else begin
                    if (m_rise[c] || m_fall[c]) begin
                        m_has[c] = 1; m_load[c] = edge_n;
                    end
                    m_rise[c] = 0; m_fall[c] = 0;
                    if (m_s2[c] != m_clean[c]) begin
                        if (m_run[c] >= int'(filt_len)) begin
                            m_clean[c] = m_s2[c]; m_rise[c] = m_s2[c]; m_fall[c] = !m_s2[c]; m_run[c] = 0;
                        end else m_run[c]++;
                    end else m_run[c] = 0;
                end
                m_act[c] = m_has[c] && (edge_n - m_load[c] < LEN);
                m_s1[c] = ns1;
                m_s2[c] = ns2;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        int first;
        int rc[N];
        input_enable = '1; filt_len = 8'd4; internal_in = '0;
        #2 rstn_sys = 1'b0; model_reset();
        #1;
        n_cmp++;
        if ({in_clean, in_rise, in_fall, input_act} !== 32'h0) begin
            n_err++; $display("FAIL reset_init: got %h expected 0", {in_clean, in_rise, in_fall, input_act});
        end
        repeat (2) tick();
        rstn_sys = 1'b1;
        internal_in = 8'hFF;
        repeat (12) tick();
        n_cmp++;
        if (in_clean !== 8'hFF || input_act !== 8'hFF) begin
            n_err++; $display("FAIL reset_preload: got clean=%h act=%h expected FF FF", in_clean, input_act);
        end
        internal_in = 8'h00;
        repeat (4) tick();
        internal_in = 8'hFF;
        rstn_sys = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (in_clean !== 8'h00) begin n_err++; $display("FAIL reset_clean: got %h expected 00", in_clean); end
        n_cmp++;
        if (in_rise !== 8'h00) begin n_err++; $display("FAIL reset_rise: got %h expected 00", in_rise); end
        n_cmp++;
        if (in_fall !== 8'h00) begin n_err++; $display("FAIL reset_fall: got %h expected 00", in_fall); end
        n_cmp++;
        if (input_act !== 8'h00) begin n_err++; $display("FAIL reset_act: got %h expected 00", input_act); end
        repeat (2) tick();
        rstn_sys = 1'b1;
        first = 0;
        for (int c = 0; c < N; c++) rc[c] = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (first == 0 && in_clean === 8'hFF) first = e;
            for (int c = 0; c < N; c++) rc[c] += int'(in_rise[c]);
        end
        n_cmp++;
        if (first != 7) begin n_err++; $display("FAIL reset_latency: got edge %0d expected edge 7", first); end
        for (int c = 0; c < N; c++) begin
            n_cmp++;
            if (rc[c] != 1) begin n_err++; $display("FAIL reset_rise_count ch%0d: got %0d expected 1", c, rc[c]); end
        end
    endtask

    task automatic test_latency;
        filt_len = 8'd3; internal_in = 8'h00;
        repeat (14) tick();
        internal_in = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_cmp++;
            if (in_clean[0] !== (e >= 6)) begin
                n_err++; $display("FAIL latency_clean e=%0d: got %b expected %b", e, in_clean[0], e >= 6);
            end
            n_cmp++;
            if (in_rise[0] !== (e == 6)) begin
                n_err++; $display("FAIL latency_rise e=%0d: got %b expected %b", e, in_rise[0], e == 6);
            end
        end
    endtask

    task automatic test_glitch;
        int sc;
        filt_len = 8'd5; internal_in = 8'h00;
        repeat (14) tick();
        sc = 0;
        for (int e = 1; e <= 14; e++) begin
            internal_in = (e <= 4) ? 8'h04 : 8'h00;
            tick();
            sc += int'(in_rise[2]) + int'(in_fall[2]);
            n_cmp++;
            if (in_clean[2] !== 1'b0) begin n_err++; $display("FAIL glitch_clean e=%0d: got %b expected 0", e, in_clean[2]); end
        end
        n_cmp++;
        if (sc != 0) begin n_err++; $display("FAIL glitch_strobes: got %0d expected 0", sc); end
        sc = 0;
        for (int e = 1; e <= 22; e++) begin
            internal_in = (e <= 7) ? 8'h04 : 8'h00;
            tick();
            sc += int'(in_rise[2]);
        end
        n_cmp++;
        if (sc != 1) begin n_err++; $display("FAIL glitch_long_rise: got %0d expected 1", sc); end
    endtask

    task automatic test_passthrough;
        logic hist[40];
        int   ns;
        filt_len = 8'd0; internal_in = 8'h00;
        repeat (6) tick();
        ns = 0;
        for (int k = 1; k <= 32; k++) begin
            hist[k] = 1'(((k - 1) / 4) % 2);
            internal_in[4] = hist[k];
            tick();
            if (k >= 3) begin
                n_cmp++;
                if (in_clean[4] !== hist[k-2]) begin
                    n_err++; $display("FAIL pass_clean k=%0d: got %b expected %b", k, in_clean[4], hist[k-2]);
                end
            end
            if (in_rise[4] || in_fall[4]) begin
                ns++;
                n_cmp++;
                if (in_rise[4] !== 1'(ns % 2) || in_fall[4] !== 1'((ns + 1) % 2)) begin
                    n_err++; $display("FAIL pass_alternate k=%0d: got rise=%b fall=%b expected rise=%b", k, in_rise[4], in_fall[4], ns % 2);
                end
            end
        end
        n_cmp++;
        if (ns != 7) begin n_err++; $display("FAIL pass_strobe_count: got %0d expected 7", ns); end
    endtask

    task automatic test_enable;
        int first;
        filt_len = 8'd3; internal_in = 8'h0A;
        repeat (12) tick();
        n_cmp++;
        if (in_clean[1] !== 1'b1 || in_clean[3] !== 1'b1) begin
            n_err++; $display("FAIL enable_pre: got clean=%h expected bits 1,3 set", in_clean);
        end
        input_enable = 8'hFD;
        tick();
        n_cmp++;
        if (in_clean[1] !== 1'b0 || in_fall[1] !== 1'b0) begin
            n_err++; $display("FAIL enable_clear: got clean=%b fall=%b expected 0 0", in_clean[1], in_fall[1]);
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            n_cmp++;
            if ({in_clean[1], in_rise[1], in_fall[1]} !== 3'b000) begin
                n_err++; $display("FAIL enable_idle e=%0d: got %b expected 000", e, {in_clean[1], in_rise[1], in_fall[1]});
            end
            n_cmp++;
            if (in_clean[3] !== 1'b1 || (in_fall[3] | in_rise[3]) !== 1'b0) begin
                n_err++; $display("FAIL enable_other e=%0d: got clean3=%b expected 1", e, in_clean[3]);
            end
        end
        input_enable = 8'hFF;
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (first == 0 && in_rise[1] === 1'b1) first = e;
        end
        n_cmp++;
        if (first != 4) begin n_err++; $display("FAIL enable_rerise: got edge %0d expected edge 4", first); end
    endtask

    task automatic test_stretch;
        bit found;
        repeat (16) tick();
        n_cmp++;
        if (input_act !== 8'h00) begin n_err++; $display("FAIL stretch_idle: got %h expected 00", input_act); end
        filt_len = 8'd0;
        internal_in[5] = 1'b1;
        found = 0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (in_rise[5] === 1'b1) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stretch_rise: got no rise strobe expected one within 8 edges"); end
        for (int i = 1; i <= 18; i++) begin
            if (i == 4) internal_in[5] = 1'b0;
            tick();
            n_cmp++;
            if (input_act[5] !== (i <= 16)) begin
                n_err++; $display("FAIL stretch_act t0+%0d: got %b expected %b", i, input_act[5], i <= 16);
            end
            if (i == 6) begin
                n_cmp++;
                if (in_fall[5] !== 1'b1) begin n_err++; $display("FAIL stretch_fall: got %b expected 1", in_fall[5]); end
            end
        end
    endtask

    task automatic test_random;
        int fast;
        int idx;
        for (int k = 0; k < 1600; k++) begin
            if (k % 100 == 0) fast = int'($urandom_range(0, 1));
            if (k % 40 == 0) filt_len = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                input_enable[idx] = ~input_enable[idx];
            end
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, fast ? 3 : 15) == 0) internal_in[c] = ~internal_in[c];
            tick();
            n_cmp++;
            if (in_clean !== m_clean) begin n_err++; $display("FAIL rnd_clean edge %0d: got %h expected %h", edge_n, in_clean, m_clean); end
            n_cmp++;
            if (in_rise !== m_rise) begin n_err++; $display("FAIL rnd_rise edge %0d: got %h expected %h", edge_n, in_rise, m_rise); end
            n_cmp++;
            if (in_fall !== m_fall) begin n_err++; $display("FAIL rnd_fall edge %0d: got %h expected %h", edge_n, in_fall, m_fall); end
            n_cmp++;
            if (input_act !== m_act) begin n_err++; $display("FAIL rnd_act edge %0d: got %h expected %h", edge_n, input_act, m_act); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_passthrough();
        test_enable();
        test_stretch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
